// File: rtl/t5_lsu.sv
// t5 load/store unit: one Wishbone data transfer per X-stage load/store, stalling the pipe until done.
// Optional misaligned-access detection is enabled by defining T5_LSU_MISALIGN_EN.
module t5_lsu #(
  parameter int XLEN = 32
) (
  input  logic            sclk,
  input  logic            srst,
  input  logic            sena,
  input  logic            xvld,
  input  logic [4:0]      xopc,
  input  logic [2:0]      xfn3,
  input  logic [XLEN-1:0] xadr,
  input  logic [XLEN-1:0] xrs2,
  input  logic            dwb_ack,
  input  logic [XLEN-1:0] dwb_dti,
  output logic [XLEN-1:0] dwb_adr,
  output logic [XLEN-1:0] dwb_dto,
  output logic [3:0]      dwb_sel,
  output logic            dwb_stb,
  output logic            dwb_cyc,
  output logic            dwb_wre,
  output logic [3:0]      xsel,
  output logic            xstb,
  output logic            xwre,
  output logic [XLEN-1:0] xdti,
  output logic            lstall,
  output logic            xmis
);

  localparam logic [4:0] OPC_LOAD  = 5'b00000;
  localparam logic [4:0] OPC_STORE = 5'b01000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            memop;
  logic            is_store;
  logic            mis;
  logic [1:0]      size;
  logic [3:0]      sel_nxt;
  logic [XLEN-1:0] dto_nxt;
  logic [XLEN-1:0] buf_q;
  logic            issue;
  logic            capture;
  logic            unused_fn3;

  assign size       = xfn3[1:0];
  assign is_store   = (xopc == OPC_STORE);
  assign memop      = xvld & ((xopc == OPC_LOAD) | is_store);
  assign unused_fn3 = xfn3[2];

`ifdef T5_LSU_MISALIGN_EN
  assign mis  = ((size == 2'd1) & xadr[0]) | ((size == 2'd2) & (|xadr[1:0]));
  assign xmis = memop & mis;
`else
  assign mis  = 1'b0;
  assign xmis = 1'b0;
`endif

  // Byte lanes and lane-replicated store data; loads drive the same pattern.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sel_nxt = 4'hF;
    dto_nxt = xrs2;
    case (size)
      2'd0: begin
        sel_nxt = 4'b0001 << xadr[1:0];
        dto_nxt = {4{xrs2[7:0]}};
      end
      2'd1: begin
        sel_nxt = xadr[1] ? 4'hC : 4'h3;
        dto_nxt = {2{xrs2[15:0]}};
      end
      default: begin
        sel_nxt = 4'hF;
        dto_nxt = xrs2;
      end
    endcase
  end

  always_ff @(posedge sclk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (srst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    capture   = 1'b0;
    lstall    = 1'b0;
    case (state)
      S_IDLE: begin
        if (memop && !mis) begin
          issue     = 1'b1;
          lstall    = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (dwb_ack) begin
          // Pipeline frozen in the ack cycle: park the read data until it moves.
          capture   = !sena;
          state_nxt = sena ? S_IDLE : S_DONE;
        end else begin
          lstall = memop & !mis;
        end
      end
      S_DONE: begin
        if (sena) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus request fields are only loaded on issue, so they stay stable through REQ and DONE.
  always_ff @(posedge sclk) begin
    if (srst) begin
      dwb_adr <= '0;
      dwb_dto <= '0;
      dwb_sel <= '0;
      dwb_wre <= 1'b0;
      xsel    <= '0;
      buf_q   <= '0;
    end else begin
      if (issue) begin
        dwb_adr <= {xadr[XLEN-1:2], 2'b00};
        dwb_dto <= dto_nxt;
        dwb_sel <= sel_nxt;
        dwb_wre <= is_store;
        xsel    <= sel_nxt;
      end
      if (capture) buf_q <= dwb_dti;
    end
  end

  assign dwb_stb = (state == S_REQ);
  assign dwb_cyc = dwb_stb;
  assign xstb    = dwb_stb;
  assign xwre    = dwb_wre;
  assign xdti    = (dwb_stb && dwb_ack) ? dwb_dti : buf_q;

endmodule

// File: tb/tb_t5_lsu.sv
// Self-checking bench for t5_lsu: scripted accesses with a queue of expected bus transactions.
module tb_t5_lsu;

  localparam logic [4:0] LOAD  = 5'b00000;
  localparam logic [4:0] STORE = 5'b01000;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dto;
    logic [3:0]  sel;
    logic        wre;
    logic [31:0] rdata;
  } exp_t;

  logic        sclk = 1'b0;
  logic        srst = 1'b1;
  logic        sena = 1'b1;
  logic        xvld = 1'b0;
  logic [4:0]  xopc = '0;
  logic [2:0]  xfn3 = '0;
  logic [31:0] xadr = '0;
  logic [31:0] xrs2 = '0;
  logic        dwb_ack = 1'b0;
  logic [31:0] dwb_dti = '0;
  logic [31:0] dwb_adr, dwb_dto, xdti;
  logic [3:0]  dwb_sel, xsel;
  logic        dwb_stb, dwb_cyc, dwb_wre, xstb, xwre, lstall, xmis;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  t5_lsu dut (
    .sclk(sclk), .srst(srst), .sena(sena), .xvld(xvld), .xopc(xopc), .xfn3(xfn3),
    .xadr(xadr), .xrs2(xrs2), .dwb_ack(dwb_ack), .dwb_dti(dwb_dti),
    .dwb_adr(dwb_adr), .dwb_dto(dwb_dto), .dwb_sel(dwb_sel), .dwb_stb(dwb_stb),
    .dwb_cyc(dwb_cyc), .dwb_wre(dwb_wre), .xsel(xsel), .xstb(xstb), .xwre(xwre),
    .xdti(xdti), .lstall(lstall), .xmis(xmis)
  );

  always #5 sclk = ~sclk;

  task automatic test_reset();
    srst = 1'b1;
    repeat (2) @(posedge sclk);
    @(negedge sclk);
    #1;
    vectors++;
    if ({dwb_adr, dwb_dto, xdti} !== 96'h0) begin
      $display("FAIL reset_data adr=%h dto=%h xdti=%h expected all 0", dwb_adr, dwb_dto, xdti);
      miscompares++;
    end
    vectors++;
    if ({dwb_sel, xsel, dwb_stb, dwb_cyc, dwb_wre, xstb, xwre, xmis, lstall} !== 15'h0) begin
      $display("FAIL reset_ctrl sel=%h xsel=%h stb=%b cyc=%b wre=%b xstb=%b xwre=%b xmis=%b lstall=%b expected 0",
               dwb_sel, xsel, dwb_stb, dwb_cyc, dwb_wre, xstb, xwre, xmis, lstall);
      miscompares++;
    end
    srst = 1'b0;
  endtask

  // Drives one access; waits = wait states before ack, hold = stalled cycles from the ack onward.
  task automatic run_access(input string name, input logic [4:0] opc, input logic [2:0] fn3,
                            input logic [31:0] adr, input logic [31:0] rs2, input int waits,
                            input logic [31:0] rdata, input int hold, input logic [31:0] e_adr,
                            input logic [31:0] e_dto, input logic [3:0] e_sel);
    exp_t e;
    exp_t got;
    int   stb_cnt = 0;
    e.adr = e_adr; e.dto = e_dto; e.sel = e_sel; e.wre = (opc == STORE); e.rdata = rdata;
    got = e;
    @(negedge sclk);
    xvld = 1'b1; xopc = opc; xfn3 = fn3; xadr = adr; xrs2 = rs2; sena = 1'b0; dwb_ack = 1'b0;
    sb.push_back(e);
    #1;
    vectors++;
    if (lstall !== 1'b1 || dwb_stb !== 1'b0 || xmis !== 1'b0) begin
      $display("FAIL %s_issue lstall=%b stb=%b xmis=%b expected 1 0 0", name, lstall, dwb_stb, xmis);
      miscompares++;
    end
    for (int k = 0; k <= waits; k++) begin
      @(negedge sclk);
      dwb_ack = (k == waits);
      dwb_dti = rdata;
      sena    = (k == waits) && (hold == 0);
      #1;
      if (dwb_stb === 1'b1) stb_cnt++;
      if (k == 0) begin
        if (sb.size() > 0) got = sb.pop_front();
        vectors++;
        if (dwb_stb !== 1'b1 || dwb_cyc !== 1'b1 || xstb !== 1'b1 || dwb_adr !== got.adr ||
            dwb_sel !== got.sel || dwb_dto !== got.dto || dwb_wre !== got.wre || xwre !== got.wre ||
            xsel !== got.sel) begin
          $display("FAIL %s_bus stb=%b cyc=%b adr=%h sel=%h dto=%h wre=%b xsel=%h expected 1 1 %h %h %h %b %h",
                   name, dwb_stb, dwb_cyc, dwb_adr, dwb_sel, dwb_dto, dwb_wre, xsel,
                   got.adr, got.sel, got.dto, got.wre, got.sel);
          miscompares++;
        end
      end
      vectors++;
      if (lstall !== (k != waits)) begin
        $display("FAIL %s_lstall_c%0d got=%b expected=%b", name, k, lstall, k != waits);
        miscompares++;
      end
      if (k == waits) begin
        vectors++;
        if (xdti !== got.rdata) begin
          $display("FAIL %s_xdti_ack got=%h expected=%h", name, xdti, got.rdata);
          miscompares++;
        end
      end
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge sclk);
      dwb_ack = 1'b0;
      dwb_dti = 32'hFFFF_FFFF;
      sena    = (i == hold - 1);
      #1;
      vectors++;
      if (dwb_stb !== 1'b0 || lstall !== 1'b0 || xdti !== got.rdata || xsel !== got.sel) begin
        $display("FAIL %s_done_%0d stb=%b lstall=%b xdti=%h xsel=%h expected 0 0 %h %h",
                 name, i, dwb_stb, lstall, xdti, xsel, got.rdata, got.sel);
        miscompares++;
      end
    end
    @(negedge sclk);
    xvld = 1'b0; dwb_ack = 1'b0; sena = 1'b1;
    #1;
    vectors++;
    if (dwb_stb !== 1'b0 || stb_cnt != waits + 1) begin
      $display("FAIL %s_end stb=%b stb_cycles=%0d expected 0 %0d", name, dwb_stb, stb_cnt, waits + 1);
      miscompares++;
    end
  endtask

  task automatic test_lw_wait();
    run_access("lw_wait", LOAD, 3'b010, 32'h100, 32'h1122_3344, 2, 32'hDEAD_BEEF, 0,
               32'h100, 32'h1122_3344, 4'hF);
  endtask

  task automatic test_sb();
    run_access("sb", STORE, 3'b000, 32'h103, 32'h1234_56A5, 0, 32'h0, 0,
               32'h100, 32'hA5A5_A5A5, 4'h8);
  endtask

  task automatic test_sh();
    run_access("sh", STORE, 3'b001, 32'h102, 32'h0000_BEEF, 1, 32'h0, 0,
               32'h100, 32'hBEEF_BEEF, 4'hC);
  endtask

  task automatic test_misaligned();
`ifdef T5_LSU_MISALIGN_EN
    @(negedge sclk);
    xvld = 1'b1; xopc = LOAD; xfn3 = 3'b010; xadr = 32'h101; sena = 1'b1;
    #1;
    vectors++;
    if (xmis !== 1'b1 || lstall !== 1'b0) begin
      $display("FAIL mis_flag xmis=%b lstall=%b expected 1 0", xmis, lstall);
      miscompares++;
    end
    repeat (2) begin
      @(negedge sclk);
      #1;
      vectors++;
      if (dwb_stb !== 1'b0 || dwb_cyc !== 1'b0) begin
        $display("FAIL mis_nobus stb=%b cyc=%b expected 0 0", dwb_stb, dwb_cyc);
        miscompares++;
      end
    end
    xvld = 1'b0;
    #1;
    vectors++;
    if (xmis !== 1'b0) begin
      $display("FAIL mis_clear xmis=%b expected 0", xmis);
      miscompares++;
    end
`else
    run_access("lw_unaligned", LOAD, 3'b010, 32'h101, 32'h5555_AAAA, 0, 32'h0BAD_F00D, 0,
               32'h100, 32'h5555_AAAA, 4'hF);
`endif
  endtask

  task automatic test_lb_done();
    run_access("lb_done", LOAD, 3'b000, 32'h200, 32'h0, 0, 32'h0000_007F, 3,
               32'h200, 32'h0, 4'h1);
  endtask

  task automatic test_srst_mid();
    @(negedge sclk);
    xvld = 1'b1; xopc = LOAD; xfn3 = 3'b010; xadr = 32'h300; sena = 1'b0; dwb_ack = 1'b0;
    @(negedge sclk);
    #1;
    vectors++;
    if (dwb_stb !== 1'b1) begin
      $display("FAIL rst_req stb=%b expected 1", dwb_stb);
      miscompares++;
    end
    srst = 1'b1;
    @(negedge sclk);
    srst = 1'b0; xvld = 1'b0; dwb_ack = 1'b1; dwb_dti = 32'h1357_9BDF;
    #1;
    vectors++;
    if (dwb_stb !== 1'b0 || dwb_cyc !== 1'b0) begin
      $display("FAIL rst_drop stb=%b cyc=%b expected 0 0", dwb_stb, dwb_cyc);
      miscompares++;
    end
    @(negedge sclk);
    #1;
    vectors++;
    if (dwb_stb !== 1'b0) begin
      $display("FAIL rst_late_ack stb=%b expected 0", dwb_stb);
      miscompares++;
    end
    // A memop with ack still high stalls only from IDLE.
    xvld = 1'b1;
    #1;
    vectors++;
    if (lstall !== 1'b1) begin
      $display("FAIL rst_idle lstall=%b expected 1", lstall);
      miscompares++;
    end
    xvld = 1'b0; dwb_ack = 1'b0; sena = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lw_wait();
    test_sb();
    test_sh();
    test_misaligned();
    test_lb_done();
    test_srst_mid();
    vectors++;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_left got=%0d expected=0", sb.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
